serial_adder: RTL and testbench

- Bit-serial N-bit adder built around the single-bit full-adder cell (ip1, ip2, ip3 -> carry, sum), with a registered carry loop.
- Sits directly downstream of that cell. It drives the cell one bit per clock, LSB first, and collects its sum/carry outputs.
- Handshake: start/busy/done. The result is held in registers until the next operation.
- Trades area for latency in the datapaths that chain the cell.

---
 rtl/serial_adder.sv | 89 ++++++++
 tb/tb_serial_adder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell driven LSB first, with its carry fed back through a register.
// Operands are captured on start; sum/cout are updated only when the last bit has been added.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] res_next, s_msb;
  logic [CW-1:0]    cnt;
  logic             c_reg;
  logic             fa_sum, fa_carry;
  logic             accept, last;

  // Full-adder cell on the current LSBs and the registered carry
  always_comb begin
    fa_sum   = a_sr[0] ^ b_sr[0] ^ c_reg;
    fa_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & c_reg) | (b_sr[0] & c_reg);
    s_msb           = '0;
    s_msb[WIDTH-1]  = fa_sum;
    res_next        = (res_sr >> 1) | s_msb;
  end

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A new accept takes priority; sum/cout are touched only on the final SHIFT edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      c_reg  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      c_reg  <= cin;
      cnt    <= '0;
      res_sr <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
      c_reg  <= fa_carry;
      cnt    <= cnt + 1'b1;
      if (last) begin
        sum  <= res_next;
        cout <= fa_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases, randomized ops against an arithmetic model,
// and an exhaustive sweep of a 2-bit instance.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start2, cin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse; returns at the falling edge just after the accepting edge
  task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int lat, output int busyCnt);
    lat = -1;
    busyCnt = busy ? 1 : 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busyCnt++;
    end
  endtask

  task automatic runOp(input string tag, input logic [7:0] ia, input logic [7:0] ib, input logic ic);
    logic [8:0] expv;
    int lat, bc;
    expv = 9'(ia) + 9'(ib) + 9'(ic);
    applyStimulus(ia, ib, ic);
    waitDone(lat, bc);
    checkOutput({tag, " latency"}, 32'(lat), 32'd8);
    checkOutput({tag, " busy cycles"}, 32'(bc), 32'd8);
    checkOutput({tag, " sum"}, 32'(sum), 32'(expv[7:0]));
    checkOutput({tag, " cout"}, 32'(cout), 32'(expv[8]));
  endtask

  initial begin
    int lat, bc, pulses, gap;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] expv;
    logic [2:0] exp2;

    start = 0; a = 0; b = 0; cin = 0;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
    rst = 1'b1;
    #2;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset sum", 32'(sum), 32'd0);
    checkOutput("reset cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runOp("3C+42", 8'h3C, 8'h42, 1'b0);
    @(negedge clk);
    checkOutput("done single cycle", 32'(done), 32'd0);
    runOp("FF+01", 8'hFF, 8'h01, 1'b0);
    runOp("A5+5A+1", 8'hA5, 8'h5A, 1'b1);
    runOp("00+00+1", 8'h00, 8'h00, 1'b1);

    // start pulsed in SHIFT cycle 3 must be ignored
    applyStimulus(8'hF0, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("ignored start pulses", 32'(pulses), 32'd1);
    checkOutput("ignored start sum", 32'(sum), 32'h10);
    checkOutput("ignored start cout", 32'(cout), 32'd1);

    // Reset in SHIFT cycle 4 clears outputs without waiting for a clock edge
    applyStimulus(8'h11, 8'h22, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkOutput("midreset sum", 32'(sum), 32'd0);
    checkOutput("midreset cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("midreset no done", 32'(pulses), 32'd0);
    runOp("after reset", 8'h3C, 8'h42, 1'b0);

    // start held high across two operations
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h80; b = 8'h80;
    waitDone(lat, bc);
    checkOutput("b2b first latency", 32'(lat), 32'd8);
    checkOutput("b2b first sum", 32'(sum), 32'h30);
    checkOutput("b2b first cout", 32'(cout), 32'd0);
    gap = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        gap = n;
        break;
      end
      if (busy) checkOutput("b2b sum held", 32'(sum), 32'h30);
    end
    start = 1'b0;
    checkOutput("b2b done spacing", 32'(gap), 32'd9);
    checkOutput("b2b second sum", 32'(sum), 32'h00);
    checkOutput("b2b second cout", 32'(cout), 32'd1);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      runOp("random", ra, rb, rc);
    end

    // Exhaustive 2-bit instance
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          a2 = 2'(ia); b2 = 2'(ib); cin2 = 1'(ic); start2 = 1'b1;
          @(negedge clk);
          start2 = 1'b0;
          lat = -1;
          for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (done2) begin
              lat = n;
              break;
            end
          end
          exp2 = 3'(ia + ib + ic);
          checkOutput("w2 latency", 32'(lat), 32'd2);
          checkOutput("w2 result", 32'({cout2, sum2}), 32'(exp2));
        end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
